// File: rtl/seg7_bcd_counter_if.sv
// ============================================================================
// Module   : seg7_bcd_counter_if
// Brief    : Count-control and display bus for seg7_bcd_counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_bcd_counter_if;
  logic        tick_in;
  logic        en;
  logic        up_down;
  logic        clear;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output tick_in, en, up_down, clear,
    input  count_bcd, wrap, an, seg, dp
  );

  modport slave (
    input  tick_in, en, up_down, clear,
    output count_bcd, wrap, an, seg, dp
  );
endinterface

`default_nettype wire

// File: rtl/seg7_bcd_counter.sv
// ============================================================================
// Module   : seg7_bcd_counter
// Brief    : Edge-counting 4-digit BCD up/down counter with a multiplexed
//            common-anode seven-segment display. Optional leading-zero
//            blanking is enabled by defining SEG7_LEAD_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_bcd_counter #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  seg7_bcd_counter_if.slave bus
);

  localparam int             PC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PC_W-1:0] c_PC_LAST = PC_W'(SCAN_DIV - 1);
  localparam logic           c_ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]     c_SEG_RST = c_ACT_LOW ? 7'h40 : 7'h3F;
  localparam logic           c_DP_ON   = ~c_ACT_LOW;
  localparam logic           c_DP_OFF  = c_ACT_LOW;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic c;
    bcd_inc = v;
    c       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          bcd_inc[4*k +: 4] = 4'd0;
        end else begin
          bcd_inc[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic b;
    bcd_dec = v;
    b       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          bcd_dec[4*k +: 4] = 4'd9;
        end else begin
          bcd_dec[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  endfunction

  // Active-high gfedcba patterns; polarity is applied afterwards.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'b0111111;
      4'd1:    decode7 = 7'b0000110;
      4'd2:    decode7 = 7'b1011011;
      4'd3:    decode7 = 7'b1001111;
      4'd4:    decode7 = 7'b1100110;
      4'd5:    decode7 = 7'b1101101;
      4'd6:    decode7 = 7'b1111101;
      4'd7:    decode7 = 7'b0000111;
      4'd8:    decode7 = 7'b1111111;
      4'd9:    decode7 = 7'b1101111;
      default: decode7 = 7'b0000000;
    endcase
  endfunction

  logic            r_s1, r_s2, r_s3;
  logic [15:0]     r_cnt;
  logic            r_wrap;
  logic [PC_W-1:0] r_pc;
  logic [1:0]      r_di;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_ev;
  logic [15:0]     w_cnt_nxt;
  logic            w_wrap_nxt;
  logic            w_pc_last;
  logic [1:0]      w_di_nxt;
  logic [3:0]      w_digit;
  logic            w_blank;
  logic [6:0]      w_pat;
  logic [6:0]      w_seg_nxt;

  // Synchronizer flops reset high so a tick_in held high through reset
  // does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= bus.tick_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_ev = r_s2 & ~r_s3;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (bus.clear) begin
      w_cnt_nxt = 16'h0000;
    end else if (w_ev && bus.en && bus.up_down) begin
      w_cnt_nxt  = bcd_inc(r_cnt);
      w_wrap_nxt = (r_cnt == 16'h9999);
    end else if (w_ev && bus.en && !bus.up_down) begin
      w_cnt_nxt  = bcd_dec(r_cnt);
      w_wrap_nxt = (r_cnt == 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 16'h0000;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign w_pc_last = (r_pc == c_PC_LAST);
  assign w_di_nxt  = w_pc_last ? (r_di + 2'd1) : r_di;

  // Segment data is taken from the next count and next digit so that seg,
  // an and count_bcd all move together on one edge.
  always_comb begin
    case (w_di_nxt)
      2'd0:    w_digit = w_cnt_nxt[3:0];
      2'd1:    w_digit = w_cnt_nxt[7:4];
      2'd2:    w_digit = w_cnt_nxt[11:8];
      default: w_digit = w_cnt_nxt[15:12];
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
`ifdef SEG7_LEAD_BLANK_EN
    case (w_di_nxt)
      2'd3:    w_blank = (w_cnt_nxt[15:12] == 4'd0);
      2'd2:    w_blank = (w_cnt_nxt[15:8]  == 8'd0);
      2'd1:    w_blank = (w_cnt_nxt[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank = 1'b0;
`endif
  end

  always_comb begin
    w_pat     = w_blank ? 7'b0000000 : decode7(w_digit);
    w_seg_nxt = c_ACT_LOW ? ~w_pat : w_pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_di  <= 2'd0;
      r_an  <= 4'b1110;
      r_seg <= c_SEG_RST;
      r_dp  <= c_DP_OFF;
    end else begin
      r_pc  <= w_pc_last ? '0 : (r_pc + 1'b1);
      r_di  <= w_di_nxt;
      r_an  <= ~(4'b0001 << w_di_nxt);
      r_seg <= w_seg_nxt;
      // r_s1 is the value r_s2 takes on this edge.
      r_dp  <= ((w_di_nxt == 2'd2) && r_s1) ? c_DP_ON : c_DP_OFF;
    end
  end

  assign bus.count_bcd = r_cnt;
  assign bus.wrap      = r_wrap;
  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.dp        = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg7_bcd_counter.sv
// ============================================================================
// Module   : tb_seg7_bcd_counter
// Brief    : Directed bench for seg7_bcd_counter (SCAN_DIV = 4, active-low).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_bcd_counter;

  logic        clk = 1'b0;
  logic        rst;
  int          vec_cnt  = 0;
  int          err_cnt  = 0;
  int          wrap_cnt = 0;
  logic [15:0] wrap_val = 16'h0;

  seg7_bcd_counter_if u_if ();

  seg7_bcd_counter #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.wrap === 1'b1) begin
      wrap_cnt = wrap_cnt + 1;
      wrap_val = u_if.count_bcd;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.tick_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 u_if.tick_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  // exp_seg[7*k +: 7] and exp_dp[k] are the values expected in slot k (k=0 units).
  task automatic scan_slots(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
    logic [3:0] prev;
    logic [3:0] exp_an;
    logic       found;
    found = 1'b0;
    prev  = u_if.an;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (u_if.an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = u_if.an;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        exp_an = ~(4'b0001 << k);
        for (int c = 0; c < 4; c++) begin
          check({tag, "_an"}, 32'(u_if.an), 32'(exp_an));
          if (c == 0) begin
            check({tag, "_seg"}, 32'(u_if.seg), 32'(exp_seg[7*k +: 7]));
            check({tag, "_dp"},  32'(u_if.dp),  32'(exp_dp[k]));
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    u_if.tick_in = 1'b1;
    u_if.en      = 1'b0;
    u_if.up_down = 1'b1;
    u_if.clear   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(u_if.count_bcd), 32'h0000);
    check("rst_wrap",  32'(u_if.wrap),      32'd0);
    check("rst_an",    32'(u_if.an),        32'b1110);
    check("rst_seg",   32'(u_if.seg),       32'b1000000);
    check("rst_dp",    32'(u_if.dp),        32'd1);

    // tick_in held high through and after reset: no event.
    u_if.en = 1'b1;
    repeat (10) @(negedge clk);
    check("no_ev_after_rst", 32'(u_if.count_bcd), 32'h0000);

    @(posedge clk);
    #1 u_if.tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 u_if.tick_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_n", 32'(u_if.count_bcd), 32'h0000);
    @(posedge clk);
    @(negedge clk);
    check("lat_n1", 32'(u_if.count_bcd), 32'h0000);
    @(posedge clk);
    @(negedge clk);
    check("lat_n2", 32'(u_if.count_bcd), 32'h0001);
    @(posedge clk);
    #1 u_if.tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulses(9);
    check("up_10", 32'(u_if.count_bcd), 32'h0010);
    check("up_no_wrap", 32'(wrap_cnt), 32'd0);

    u_if.up_down = 1'b0;
    pulses(10);
    check("down_to_0", 32'(u_if.count_bcd), 32'h0000);
    check("down_no_wrap", 32'(wrap_cnt), 32'd0);
    pulses(1);
    check("down_wrap_cnt", 32'(u_if.count_bcd), 32'h9999);
    check("down_wrap_once", 32'(wrap_cnt), 32'd1);
    check("down_wrap_val", 32'(wrap_val), 32'h9999);
    u_if.up_down = 1'b1;
    pulses(1);
    check("up_wrap_cnt", 32'(u_if.count_bcd), 32'h0000);
    check("up_wrap_once", 32'(wrap_cnt), 32'd2);
    check("up_wrap_val", 32'(wrap_val), 32'h0000);

    pulses(3);
    check("up_3", 32'(u_if.count_bcd), 32'h0003);
    u_if.en = 1'b0;
    pulses(5);
    check("en_off_hold", 32'(u_if.count_bcd), 32'h0003);
    u_if.en = 1'b1;

    // clear lands in the same cycle that the event is live.
    u_if.tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 u_if.clear = 1'b1;
    @(posedge clk);
    #1 u_if.clear = 1'b0;
    @(negedge clk);
    check("clear_ev_cnt",  32'(u_if.count_bcd), 32'h0000);
    check("clear_ev_wrap", 32'(u_if.wrap),      32'd0);
    @(posedge clk);
    #1 u_if.tick_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("clear_ev_lost", 32'(u_if.count_bcd), 32'h0000);
    check("clear_no_wrap", 32'(wrap_cnt), 32'd2);

    pulses(1234);
    check("up_1234", 32'(u_if.count_bcd), 32'h1234);
    u_if.en      = 1'b0;
    u_if.tick_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    scan_slots("scan1234_hi", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);
    u_if.tick_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    scan_slots("scan1234_lo", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    check("scan_hold", 32'(u_if.count_bcd), 32'h1234);

    @(posedge clk);
    #1 u_if.clear = 1'b1;
    @(posedge clk);
    #1 u_if.clear = 1'b0;
`ifdef SEG7_LEAD_BLANK_EN
    scan_slots("scan0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
`else
    scan_slots("scan0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
`endif
    u_if.en = 1'b1;
    @(posedge clk);
    #1;
    pulses(42);
    check("up_42", 32'(u_if.count_bcd), 32'h0042);
`ifdef SEG7_LEAD_BLANK_EN
    scan_slots("scan0042", {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111);
`else
    scan_slots("scan0042", {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1111);
`endif

    // Reset with an event in flight: it must be discarded.
    @(posedge clk);
    #1 u_if.tick_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(u_if.count_bcd), 32'h0000);
    check("midrst_an",    32'(u_if.an),        32'b1110);
    check("midrst_seg",   32'(u_if.seg),       32'b1000000);
    check("midrst_wrap",  32'(u_if.wrap),      32'd0);
    repeat (5) @(negedge clk);
    check("midrst_ev_lost", 32'(u_if.count_bcd), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
